uart_rx_8n1: RTL and testbench



---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_8n1_sync_fifo.sv | 61 ++++++
 rtl/uart_rx_8n1.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_8n1.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_e;

  localparam int unsigned UART_DATA_BITS = 8;

  // Width of the per-bit cycle counter
  function automatic int unsigned uart_cnt_width(input int unsigned clks_per_bit);
    return $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_8n1_sync_fifo.sv
// Synchronous FIFO with registered push/pop and a combinational head output.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    rd_idx;
  logic [AW-1:0]    last_idx;
  logic             do_push;
  logic             do_pop;

  // Full/empty flags and head selection; an empty FIFO keeps showing the
  // most recently popped entry
  always_comb begin
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    rd_idx   = rd_ptr[AW-1:0];
    last_idx = rd_idx - IDX_ONE;
    do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is kept
    do_push  = push && (!full || do_pop);
    head_data = empty ? mem[last_idx] : mem[rd_idx];
  end

  // Storage and pointer update
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: input synchronizer, oversampling FSM, shift register,
// sticky error flags and a small receive FIFO with valid/ready output.
module uart_rx_8n1
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 32,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clr_err_i,
  output logic       busy_o
);

  localparam int unsigned CW = uart_cnt_width(CLKS_PER_BIT);
  localparam int unsigned IW = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(UART_DATA_BITS - 1);
  localparam logic [IW-1:0] IDX_ONE   = IW'(1);

  uart_rx_state_e state, state_next;

  logic                      rx_meta;
  logic                      rx_s;
  logic                      rx_prev;
  logic [CW-1:0]             cnt;
  logic [IW-1:0]             idx;
  logic [UART_DATA_BITS-1:0] shift_reg;

  logic half_end;
  logic bit_end;
  logic cnt_clr;
  logic shift_en;
  logic push_req;
  logic frame_set;
  logic overrun_set;
  logic fifo_full;
  logic fifo_empty;
  logic pop;

  assign half_end = (cnt == HALF_LAST);
  assign bit_end  = (cnt == BIT_LAST);

  // Two-flop synchronizer plus previous-sample register for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (rx_prev && !rx_s) state_next = START;
      START:     if (half_end) state_next = rx_s ? IDLE : DATA;
      DATA:      if (bit_end && (idx == IDX_LAST)) state_next = STOP;
      STOP:      if (bit_end) state_next = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // FSM outputs: counter control, sampling strobes and status
  always_comb begin
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    frame_set = 1'b0;
    busy_o    = (state != IDLE);
    case (state)
      IDLE:  cnt_clr = 1'b1;
      START: cnt_clr = half_end;
      DATA: begin
        cnt_clr  = bit_end;
        shift_en = bit_end;
      end
      STOP: begin
        push_req  = bit_end && rx_s;
        frame_set = bit_end && !rx_s;
      end
      default: ;
    endcase
  end

  // Bit-period counter, bit index and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      idx       <= '0;
      shift_reg <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CNT_ONE;
      if (state != DATA) begin
        idx <= '0;
      end else if (shift_en) begin
        idx <= idx + IDX_ONE;
      end
      if (shift_en) begin
        shift_reg <= {rx_s, shift_reg[UART_DATA_BITS-1:1]};
      end
    end
  end

  assign pop         = rx_valid_o && rx_ready_i;
  assign overrun_set = push_req && fifo_full && !pop;
  assign rx_valid_o  = !fifo_empty;

  // Sticky error flags; clearing wins over a same-cycle set
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else if (clr_err_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= frame_err_o | frame_set;
      overrun_o   <= overrun_o | overrun_set;
    end
  end

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (shift_reg),
    .pop       (pop),
    .head_data (rx_data_o),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_rx_8n1.sv
// Self-checking bench for uart_rx_8n1: serial frames in, popped bytes and
// flags compared with a queue-based model of the expected byte stream.
module tb_uart_rx_8n1;

  localparam int CPB   = 32;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic       rx_ready_i = 1'b0;
  logic       clr_err_i = 1'b0;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  logic [7:0] got[$];
  logic [7:0] model_q[$];
  int         model_held = 0;
  logic       model_ovr  = 1'b0;
  int         valid_hi   = 0;

  always #5 clk = ~clk;

  uart_rx_8n1 #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .rx_data_o   (rx_data_o),
    .rx_valid_o  (rx_valid_o),
    .rx_ready_i  (rx_ready_i),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o),
    .clr_err_i   (clr_err_i),
    .busy_o      (busy_o)
  );

  // Consumer side: record every accepted byte and count valid cycles
  always @(negedge clk) begin
    if (rx_valid_o && rx_ready_i) got.push_back(rx_data_o);
    if (rx_valid_o) valid_hi++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Serial frame: start bit, 8 data bits LSB first, stop bit, each bp cycles
  task automatic send_byte(input logic [7:0] b, input int bp, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = frame[i];
      tick(bp);
    end
  endtask

  // Model: a good frame is delivered unless the consumer is stalled and
  // DEPTH bytes are already waiting, in which case it is lost as an overrun
  task automatic model_frame(input logic [7:0] b);
    if (rx_ready_i) begin
      model_q.push_back(b);
    end else if (model_held < DEPTH) begin
      model_q.push_back(b);
      model_held++;
    end else begin
      model_ovr = 1'b1;
    end
  endtask

  task automatic send_good(input logic [7:0] b, input int bp);
    send_byte(b, bp, 1'b1);
    model_frame(b);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_count"}, 32'(got.size()), 32'(model_q.size()));
    n = (got.size() < model_q.size()) ? got.size() : model_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(model_q[i]));
    end
    got.delete();
    model_q.delete();
    model_held = 0;
  endtask

  initial begin
    logic [7:0] b;
    logic       seen_busy;
    int         n_back;

    // Reset values
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    chk("rst_data",  32'(rx_data_o),   32'h00);
    chk("rst_valid", 32'(rx_valid_o),  32'h0);
    chk("rst_ferr",  32'(frame_err_o), 32'h0);
    chk("rst_ovr",   32'(overrun_o),   32'h0);
    chk("rst_busy",  32'(busy_o),      32'h0);
    tick(5);

    // Single byte with consumer ready: one-cycle valid pulse
    rx_ready_i = 1'b1;
    valid_hi = 0;
    send_good(8'h65, CPB);
    tick(CPB);
    chk("single_valid_cycles", 32'(valid_hi), 32'd1);
    compare_stream("single");
    chk("single_ferr", 32'(frame_err_o), 32'h0);
    chk("single_ovr",  32'(overrun_o),   32'h0);

    // Random bytes at nominal rate and at +-3 % baud mismatch
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      send_good(b, CPB);
    end
    send_good(8'($urandom), CPB - 1);
    send_good(8'($urandom), CPB + 1);
    send_good(8'($urandom), CPB - 1);
    send_good(8'($urandom), CPB + 1);
    tick(CPB);
    compare_stream("random");
    chk("random_ferr", 32'(frame_err_o), 32'h0);

    // Back-to-back frames into a stalled consumer, drained afterwards
    rx_ready_i = 1'b0;
    send_good(8'h00, CPB);
    send_good(8'hFF, CPB);
    send_good(8'hA5, CPB);
    send_good(8'h5A, CPB);
    tick(CPB);
    chk("b2b_valid", 32'(rx_valid_o), 32'h1);
    chk("b2b_head",  32'(rx_data_o),  32'h00);
    rx_ready_i = 1'b1;
    tick(10);
    compare_stream("b2b");
    chk("b2b_ovr", 32'(overrun_o), 32'(model_ovr));

    // Five bytes into a stalled 4-entry FIFO: fifth byte lost, overrun set
    rx_ready_i = 1'b0;
    model_ovr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_good(8'($urandom), CPB);
    end
    tick(CPB);
    chk("ovr_flag", 32'(overrun_o), 32'(model_ovr));
    chk("ovr_ferr", 32'(frame_err_o), 32'h0);
    rx_ready_i = 1'b1;
    tick(10);
    compare_stream("ovr");
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    chk("ovr_cleared", 32'(overrun_o), 32'h0);
    model_ovr = 1'b0;

    // Stop bit held low: frame error, nothing pushed, FSM parked until line high
    valid_hi = 0;
    send_byte(8'h3C, CPB, 1'b0);
    tick(3 * CPB);
    chk("ferr_flag",  32'(frame_err_o), 32'h1);
    chk("ferr_busy",  32'(busy_o),      32'h1);
    chk("ferr_nopop", 32'(valid_hi),    32'd0);
    rx_i = 1'b1;
    tick(5);
    chk("ferr_idle", 32'(busy_o), 32'h0);
    send_good(8'h12, CPB);
    tick(CPB);
    compare_stream("ferr_next");
    chk("ferr_sticky", 32'(frame_err_o), 32'h1);
    clr_err_i = 1'b1;
    tick(1);
    clr_err_i = 1'b0;
    chk("ferr_cleared", 32'(frame_err_o), 32'h0);

    // Ten-cycle low glitch on an idle line
    tick(CPB);
    valid_hi  = 0;
    seen_busy = 1'b0;
    n_back    = 0;
    rx_i      = 1'b0;
    for (int n = 1; n <= 3 * CPB; n++) begin
      tick(1);
      if (n == 10) rx_i = 1'b1;
      if (busy_o) seen_busy = 1'b1;
      else if (seen_busy && n_back == 0) n_back = n;
    end
    chk("glitch_seen_busy", 32'(seen_busy), 32'h1);
    chk("glitch_busy_returns", 32'(n_back != 0 && n_back <= CPB / 2 + 3), 32'h1);
    chk("glitch_nopush", 32'(valid_hi),    32'd0);
    chk("glitch_ferr",   32'(frame_err_o), 32'h0);
    chk("glitch_ovr",    32'(overrun_o),   32'h0);

    // Reset during data bit 3 with a byte buffered and a flag set
    send_byte(8'h81, CPB, 1'b0);
    rx_i = 1'b1;
    tick(5);
    rx_ready_i = 1'b0;
    send_byte(8'h5A, CPB, 1'b1);
    tick(CPB);
    chk("pre_rst_valid", 32'(rx_valid_o),  32'h1);
    chk("pre_rst_data",  32'(rx_data_o),   32'h5A);
    chk("pre_rst_ferr",  32'(frame_err_o), 32'h1);
    b = 8'hC3;
    rx_i = 1'b0;
    tick(CPB);
    for (int i = 0; i < 3; i++) begin
      rx_i = b[i];
      tick(CPB);
    end
    rx_i = b[3];
    tick(CPB / 2);
    chk("pre_rst_busy", 32'(busy_o), 32'h1);
    rst = 1'b1;
    tick(1);
    chk("mid_rst_data",  32'(rx_data_o),   32'h00);
    chk("mid_rst_valid", 32'(rx_valid_o),  32'h0);
    chk("mid_rst_ferr",  32'(frame_err_o), 32'h0);
    chk("mid_rst_ovr",   32'(overrun_o),   32'h0);
    chk("mid_rst_busy",  32'(busy_o),      32'h0);
    rst = 1'b0;
    rx_i = 1'b1;
    got.delete();
    model_q.delete();
    model_held = 0;
    tick(CPB);
    rx_ready_i = 1'b1;
    send_good(8'hC3, CPB);
    tick(CPB);
    compare_stream("post_rst");
    chk("post_rst_ferr", 32'(frame_err_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
